// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the asynchronous FIFO: owns the read pointer, detects empty
// against the synchronised write pointer and feeds a one-entry valid/ready output stage.
module fifo_rd_ctrl #(
    parameter int WIDTH    = 8,
    parameter int ADDRESS  = 4,
    parameter int DEPTH    = 8,
    parameter int AE_LEVEL = 2
) (
    input  logic                 R_CLK,
    input  logic                 R_RST,
    input  logic [ADDRESS-1:0]   RQ2_WPTR,
    input  logic [WIDTH-1:0]     MEM_RDATA,
    input  logic                 RD_READY,
    output logic [ADDRESS-2:0]   R_ADDR,
    output logic [ADDRESS-1:0]   RPTR_GRAY,
    output logic [WIDTH-1:0]     RD_DATA,
    output logic                 RD_VALID,
    output logic                 R_EMPTY,
    output logic                 R_ALMOST_EMPTY,
    output logic [ADDRESS-1:0]   R_LEVEL
);

    localparam int unsigned      ADDR_W    = $clog2(DEPTH);
    localparam logic [ADDRESS:0] AE_THRESH = (ADDRESS+1)'(AE_LEVEL);

    logic [ADDRESS-1:0] rbin_q, rbin_d;
    logic [ADDRESS-1:0] rgray_q, rgray_d;
    logic [WIDTH-1:0]   rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;

    logic               take;
    logic               fetch;
    logic               mem_empty;
    logic [ADDRESS-1:0] rbin_inc;
    logic [ADDRESS-1:0] wbin;
    logic [ADDRESS-1:0] level;
    logic [ADDRESS:0]   level_plus_stage;

    always_comb begin
        take      = rd_valid_q & RD_READY;
        mem_empty = (rgray_q == RQ2_WPTR);
        fetch     = !mem_empty & (!rd_valid_q | take);
        rbin_inc  = rbin_q + ADDRESS'(1);

        rbin_d     = rbin_q;
        rgray_d    = rgray_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;

        if (fetch) begin
            rd_data_d  = MEM_RDATA;
            rd_valid_d = 1'b1;
            rbin_d     = rbin_inc;
            rgray_d    = rbin_inc ^ (rbin_inc >> 1);
        end else if (take) begin
            rd_valid_d = 1'b0;
        end
    end

    // Each binary bit of the write pointer is the XOR of all Gray bits at or above it.
    always_comb begin
        wbin = '0;
        for (int unsigned j = 0; j < ADDRESS; j++) begin
            wbin[j] = ^(RQ2_WPTR >> j);
        end
        level            = wbin - rbin_q;
        level_plus_stage = {1'b0, level} + {{ADDRESS{1'b0}}, rd_valid_q};
    end

    always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
            rbin_q     <= '0;
            rgray_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rbin_q     <= rbin_d;
            rgray_q    <= rgray_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign R_ADDR         = rbin_q[ADDR_W-1:0];
    assign RPTR_GRAY      = rgray_q;
    assign RD_DATA        = rd_data_q;
    assign RD_VALID       = rd_valid_q;
    assign R_EMPTY        = !rd_valid_q;
    assign R_LEVEL        = level;
    assign R_ALMOST_EMPTY = (level_plus_stage <= AE_THRESH);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: a queue-based FIFO model drives a behavioural memory and write pointer.
module tb_fifo_rd_ctrl;

    logic       R_CLK;
    logic       R_RST;
    logic [3:0] RQ2_WPTR;
    logic [7:0] MEM_RDATA;
    logic       RD_READY;
    logic [2:0] R_ADDR;
    logic [3:0] RPTR_GRAY;
    logic [7:0] RD_DATA;
    logic       RD_VALID;
    logic       R_EMPTY;
    logic       R_ALMOST_EMPTY;
    logic [3:0] R_LEVEL;

    fifo_rd_ctrl #(
        .WIDTH   (8),
        .ADDRESS (4),
        .DEPTH   (8),
        .AE_LEVEL(2)
    ) dut (
        .R_CLK         (R_CLK),
        .R_RST         (R_RST),
        .RQ2_WPTR      (RQ2_WPTR),
        .MEM_RDATA     (MEM_RDATA),
        .RD_READY      (RD_READY),
        .R_ADDR        (R_ADDR),
        .RPTR_GRAY     (RPTR_GRAY),
        .RD_DATA       (RD_DATA),
        .RD_VALID      (RD_VALID),
        .R_EMPTY       (R_EMPTY),
        .R_ALMOST_EMPTY(R_ALMOST_EMPTY),
        .R_LEVEL       (R_LEVEL)
    );

    initial R_CLK = 1'b0;
    always #5 R_CLK = ~R_CLK;

    // Behavioural write side: memory array plus a binary write count published in Gray.
    logic [7:0] mem [8];
    logic [3:0] wbin;
    assign MEM_RDATA = mem[R_ADDR];
    assign RQ2_WPTR  = wbin ^ (wbin >> 1);

    // Model: words written but not yet read, the output slot, and the total read count.
    logic [7:0] q[$];
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [3:0] rcnt;

    int tests;
    int fails;

    function automatic logic [3:0] gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] d);
        mem[wbin[2:0]] = d;
        q.push_back(d);
        wbin = wbin + 4'd1;
    endtask

    task automatic check_regs(input string phase);
        chk({phase, ".valid"}, RD_VALID, exp_valid);
        chk({phase, ".empty"}, R_EMPTY, !exp_valid);
        if (exp_valid) chk({phase, ".data"}, RD_DATA, exp_data);
        chk({phase, ".gray"}, RPTR_GRAY, gray(rcnt));
        chk({phase, ".addr"}, R_ADDR, rcnt[2:0]);
    endtask

    // Called at posedge+1: checks combinational status, clocks once, updates model, checks registers.
    task automatic step(input logic rdy);
        int sz;
        RD_READY = rdy;
        #1;
        sz = q.size();
        chk("level", R_LEVEL, sz);
        chk("almost_empty", R_ALMOST_EMPTY, (sz + int'(exp_valid)) <= 2);
        @(posedge R_CLK);
        #1;
        if (exp_valid && rdy) exp_valid = 1'b0;
        if (!exp_valid && q.size() > 0) begin
            exp_data  = q.pop_front();
            exp_valid = 1'b1;
            rcnt      = rcnt + 4'd1;
        end
        check_regs("step");
    endtask

    // Asserts reset away from a clock edge and checks the outputs respond without a clock.
    task automatic do_reset();
        #2;
        R_RST = 1'b0;
        #1;
        chk("rst.valid", RD_VALID, 1'b0);
        chk("rst.data", RD_DATA, 8'h00);
        chk("rst.gray", RPTR_GRAY, 4'h0);
        chk("rst.addr", R_ADDR, 3'd0);
        chk("rst.empty", R_EMPTY, 1'b1);
        wbin      = 4'd0;
        q.delete();
        exp_valid = 1'b0;
        exp_data  = 8'h00;
        rcnt      = 4'd0;
        #1;
        chk("rst.level", R_LEVEL, 4'd0);
        chk("rst.ae", R_ALMOST_EMPTY, 1'b1);
        @(negedge R_CLK);
        R_RST = 1'b1;
        @(posedge R_CLK);
        #1;
    endtask

    initial begin
        int n;
        tests     = 0;
        fails     = 0;
        R_RST     = 1'b0;
        RD_READY  = 1'b0;
        wbin      = 4'd0;
        rcnt      = 4'd0;
        exp_valid = 1'b0;
        exp_data  = 8'h00;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        #7;
        do_reset();

        // Single word held under backpressure, then consumed.
        push_word(8'hA5);
        step(1'b0);
        chk("single.data", RD_DATA, 8'hA5);
        for (int i = 0; i < 5; i++) step(1'b0);
        step(1'b1);
        chk("single.empty", R_EMPTY, 1'b1);

        // Full-depth burst from a clean pointer.
        do_reset();
        for (int i = 0; i < 8; i++) push_word(8'h10 + 8'(i));
        for (int i = 0; i < 10; i++) step(1'b1);

        // Wrap-around: keep the write side up to 8 ahead for 20 words.
        do_reset();
        n = 0;
        for (int i = 0; i < 26; i++) begin
            while (q.size() < 8 && n < 20) begin
                push_word(8'(8'h40 + n));
                n++;
            end
            step(1'b1);
        end
        chk("wrap.gray", RPTR_GRAY, gray(4'd4));

        // Backpressure pattern with four words pending.
        for (int i = 0; i < 4; i++) push_word(8'($urandom));
        step(1'b1); step(1'b0); step(1'b0); step(1'b1); step(1'b1);
        for (int i = 0; i < 4; i++) step(1'b1);

        // Late write pointer: jump of four words in one cycle.
        do_reset();
        for (int i = 0; i < 4; i++) push_word(8'hC0 + 8'(i));
        for (int i = 0; i < 6; i++) step(1'b1);

        // Randomised traffic, memory never overfilled.
        for (int i = 0; i < 400; i++) begin
            n = int'($urandom_range(0, 3));
            while (n > 0 && q.size() < 8) begin
                push_word(8'($urandom));
                n--;
            end
            step(($urandom % 3) != 0);
        end

        // Reset mid-transfer with a word in the output stage; nothing emitted afterwards.
        for (int i = 0; i < 3; i++) push_word(8'($urandom));
        step(1'b0);
        chk("midrst.pre_valid", RD_VALID, 1'b1);
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side controller for the asynchronous FIFO, running entirely in the read clock domain. It owns the read pointer, produces the read address into the FIFO memory, and publishes a Gray-coded read pointer for synchronisation into the write domain. It compares its pointer against the synchronised write pointer to detect empty. It presents data to the consumer through a one-entry registered output stage with a valid/ready handshake.

## Interface
- WIDTH, 8, data word width
- ADDRESS, 4, pointer width including the wrap bit; memory address is ADDRESS-1 bits
- DEPTH, 8, memory entries; must equal 2^(ADDRESS-1)
- AE_LEVEL, 2, almost-empty threshold in words
- R_CLK  in  1  read-domain clock, rising edge
- R_RST  in  1  asynchronous, active-low reset
- RQ2_WPTR  in  ADDRESS  Gray write pointer, already double-flop synchronised into R_CLK
- MEM_RDATA  in  WIDTH  combinational memory read data at R_ADDR
- RD_READY  in  1  consumer accepts RD_DATA this cycle
- R_ADDR  out  ADDRESS-1  memory read address = rbin[ADDRESS-2:0]
- RPTR_GRAY  out  ADDRESS  registered Gray read pointer, sent to the write-side synchroniser
- RD_DATA  out  WIDTH  registered output word
- RD_VALID  out  1  RD_DATA holds an unconsumed word
- R_EMPTY  out  1  equals !RD_VALID
- R_ALMOST_EMPTY  out  1  (R_LEVEL + RD_VALID) <= AE_LEVEL
- R_LEVEL  out  ADDRESS  words still in memory, excluding the output stage

## Operation
- Internal binary pointer `rbin` is ADDRESS bits wide. RPTR_GRAY is the registered value `rbin ^ (rbin >> 1)`, updated in the same edge as rbin.
- `mem_empty = (RPTR_GRAY == RQ2_WPTR)`, combinational on register values.
- `take = RD_VALID & RD_READY`.
- `fetch = !mem_empty & (!RD_VALID | take)`.
- On fetch:
  - RD_DATA <= MEM_RDATA
  - RD_VALID <= 1
  - rbin <= rbin + 1 (mod 2^ADDRESS)
  - RPTR_GRAY <= gray(rbin + 1)
- On take without fetch: RD_VALID <= 0. RD_DATA holds its value.
- With neither take nor fetch, all registers hold.
- R_LEVEL = gray2bin(RQ2_WPTR) - rbin, modulo 2^ADDRESS, combinational.
- RD_READY while RD_VALID=0 has no effect.
- Wrap-around: rbin goes from 2^ADDRESS-1 to 0, and RPTR_GRAY from 1000 to 0000 at ADDRESS=4. R_ADDR wraps from DEPTH-1 to 0. The wrap bit toggles every DEPTH reads.
- RQ2_WPTR may advance by any amount between edges. Only its sampled value matters.
- The block does no full or overflow detection; that is the write side's job.

## Timing
- Reset (asynchronous, while R_RST=0):
  - rbin = 0, RPTR_GRAY = 0, R_ADDR = 0, RD_DATA = 0, RD_VALID = 0
  - R_EMPTY = 1
  - R_LEVEL and R_ALMOST_EMPTY are combinational from RQ2_WPTR; with RQ2_WPTR = 0 they are 0 and 1.
- Reset mid-operation discards the word in the output stage and the read position immediately; nothing is emitted afterwards until RQ2_WPTR differs from 0.
- Latency:
  - RQ2_WPTR becomes != RPTR_GRAY before edge N with the stage empty → RD_VALID=1 and RD_DATA=mem[R_ADDR] after edge N.
  - Each fetch advances RPTR_GRAY in that same edge N.
- Throughput is one word per cycle while RD_READY=1 and memory is non-empty. No bubble on simultaneous take and fetch.
- RD_DATA and RD_VALID must stay stable while RD_VALID=1 and RD_READY=0.
- Last word (R_LEVEL=0, RD_VALID=1, RD_READY=1): RD_VALID falls after the edge and R_EMPTY rises.

## Test plan
- **Reset:** assert R_RST=0 mid-transfer with RD_VALID=1 → immediately RD_VALID=0, RD_DATA=0, RPTR_GRAY=0000, R_ADDR=0, independent of R_CLK.
- **Single word:** mem[0]=0xA5, RQ2_WPTR=0001, RD_READY=0 → after 1 edge RD_VALID=1, RD_DATA=0xA5, RPTR_GRAY=0001, R_LEVEL=0; hold 5 cycles, all stable; RD_READY=1 for one edge → RD_VALID=0, R_EMPTY=1.
- **Burst:** mem[0..7]=0x10..0x17, RQ2_WPTR=gray(8)=1100, RD_READY=1 → 0x10..0x17 on 8 consecutive cycles, then RD_VALID=0. R_ALMOST_EMPTY=0 until R_LEVEL+RD_VALID<=2.
- **Wrap-around:** run 20 words through with the write pointer kept ≤8 ahead → RPTR_GRAY sequence matches gray(1..20), R_ADDR wraps 7→0 twice, and the data order is preserved.
- **Backpressure mid-burst:** 4 words pending, toggle RD_READY 1,0,0,1,1 → no word is lost or duplicated, and rbin advances only on fetch edges.
- **Late write pointer:** RQ2_WPTR jumps 0000→0110 (bin 4) in one cycle → R_LEVEL=4 before the first fetch, and 4 words are then delivered in order.
